// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the EX-stage branch unit:
//   - br_type_e : encoding of the br_type input (9..15 decode as NONE)
//   - state_e   : shadow FSM states
//   - SHADOW_CYCLES_DEFAULT : default number of wrong-path cycles squashed
//   - isJump()  : true for the unconditional link-producing types
// ---------------------------------------------------------------------------
package branch_pkg;

    localparam int SHADOW_CYCLES_DEFAULT = 2;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_e;

    // JAL and JALR both write a link register and are always taken
    function automatic logic isJump(input logic [3:0] brType);
        return (brType == BR_JAL) || (brType == BR_JALR);
    endfunction

endpackage

// File: rtl/branch_compare.sv
// ---------------------------------------------------------------------------
// branch_compare
// Purely combinational branch condition evaluator.
// Ports:
//   br_type  in  [3:0]     branch type (br_type_e encoding)
//   rs1_val  in  [XLEN-1:0] first source operand
//   rs2_val  in  [XLEN-1:0] second source operand
//   taken    out           1 when the branch condition holds
// ---------------------------------------------------------------------------
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      br_type,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            taken
);

    // Unused and reserved encodings fall through to the default and are never taken
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = (rs1_val == rs2_val);
            BR_BNE:  taken = (rs1_val != rs2_val);
            BR_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            BR_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            BR_BLTU: taken = (rs1_val <  rs2_val);
            BR_BGEU: taken = (rs1_val >= rs2_val);
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_branch_unit.sv
// ---------------------------------------------------------------------------
// ex_branch_unit
// EX-stage branch resolution: evaluates the condition, computes the redirect
// target, produces a registered redirect pulse plus a link value for JAL/JALR,
// and squashes wrong-path instructions for SHADOW_CYCLES cycles afterwards.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid          EX instruction valid
//   pc                PC of EX instruction
//   rs1_val, rs2_val  source operands
//   imm               sign-extended offset
//   br_type           branch type (br_type_e)
//   isBranchTaken     1-cycle redirect pulse
//   branchPC          redirect target (holds between redirects)
//   flush             squash IF/ID while in the shadow
//   link_valid        1-cycle pulse, link_value valid
//   link_value        pc+4 of the last accepted JAL/JALR
//   taken_count       saturating count of redirects
// SHADOW_CYCLES is expected to be in 1..3 (2-bit shadow counter); 0 disables
// the shadow entirely.
// ---------------------------------------------------------------------------
module ex_branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int SHADOW_CYCLES = SHADOW_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      br_type,
    output logic            isBranchTaken,
    output logic [XLEN-1:0] branchPC,
    output logic            flush,
    output logic            link_valid,
    output logic [XLEN-1:0] link_value,
    output logic [15:0]     taken_count
);

    localparam logic [1:0] SHADOW_LOAD = 2'(SHADOW_CYCLES);

    state_e          state_q, state_d;
    logic [1:0]      shadowCnt_q, shadowCnt_d;
    logic            isBranchTaken_q, isBranchTaken_d;
    logic [XLEN-1:0] branchPC_q, branchPC_d;
    logic            linkValid_q, linkValid_d;
    logic [XLEN-1:0] linkValue_q, linkValue_d;
    logic [15:0]     takenCount_q, takenCount_d;

    logic            condTaken;
    logic            accept;
    logic            takenNow;
    logic [XLEN-1:0] jalrSum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pcPlus4;

    branch_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .br_type (br_type),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .taken   (condTaken)
    );

    // Anything presented while in the shadow is a wrong-path instruction
    assign accept   = in_valid && (state_q == ST_IDLE);
    assign takenNow = accept && condTaken;

    // JALR clears bit 0 of the sum; additions wrap naturally at XLEN bits
    assign jalrSum = rs1_val + imm;
    assign target  = (br_type == BR_JALR) ? {jalrSum[XLEN-1:1], 1'b0} : (pc + imm);
    assign pcPlus4 = pc + XLEN'(4);

    // State and output registers; reset overrides any same-cycle branch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            shadowCnt_q     <= 2'd0;
            isBranchTaken_q <= 1'b0;
            branchPC_q      <= '0;
            linkValid_q     <= 1'b0;
            linkValue_q     <= '0;
            takenCount_q    <= 16'd0;
        end else begin
            state_q         <= state_d;
            shadowCnt_q     <= shadowCnt_d;
            isBranchTaken_q <= isBranchTaken_d;
            branchPC_q      <= branchPC_d;
            linkValid_q     <= linkValid_d;
            linkValue_q     <= linkValue_d;
            takenCount_q    <= takenCount_d;
        end
    end

    // Shadow FSM next state: counter loads on entry and leaves after SHADOW_CYCLES cycles
    always_comb begin
        state_d     = state_q;
        shadowCnt_d = shadowCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (takenNow && (SHADOW_LOAD != 2'd0)) begin
                    state_d     = ST_SHADOW;
                    shadowCnt_d = SHADOW_LOAD;
                end
            end
            ST_SHADOW: begin
                if (shadowCnt_q <= 2'd1) begin
                    state_d     = ST_IDLE;
                    shadowCnt_d = 2'd0;
                end else begin
                    shadowCnt_d = shadowCnt_q - 2'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                shadowCnt_d = 2'd0;
            end
        endcase
    end

    // Next values of the registered outputs; branchPC and link_value hold when not loaded
    always_comb begin
        isBranchTaken_d = takenNow;
        branchPC_d      = takenNow ? target : branchPC_q;
        linkValid_d     = accept && isJump(br_type);
        linkValue_d     = linkValid_d ? pcPlus4 : linkValue_q;
        takenCount_d    = takenCount_q;
        if (takenNow && (takenCount_q != 16'hFFFF)) begin
            takenCount_d = takenCount_q + 16'd1;
        end
    end

    assign isBranchTaken = isBranchTaken_q;
    assign branchPC      = branchPC_q;
    assign flush         = (state_q == ST_SHADOW);
    assign link_valid    = linkValid_q;
    assign link_value    = linkValue_q;
    assign taken_count   = takenCount_q;

endmodule
